gpu_cmd_fifo: RTL and testbench

- Upstream front-end of the gpu block. Accepts CPU command writes ({code, data}) at full clock rate and buffers them in a FIFO.
- Replays each command to the gpu as a paced interrupt transaction: code/data set up, interrupt_enable pulsed, then held through a gap.
- SIG_DISPLAY (buffer swap) commands are held back until vertical blank, so swaps never tear mid-frame.

---
 rtl/gpu_cmd_fifo.sv | 145 ++++++++++++++
 tb/tb_gpu_cmd_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: buffers CPU command writes and replays each one to the gpu
// as a paced interrupt transaction; DISPLAY commands wait for vblank.
module gpu_cmd_fifo #(
    parameter int DEPTH        = 16,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [1:0]             wr_code,
    input  logic [7:0]             wr_data,
    input  logic                   hold,
    input  logic                   vblank,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop,
    output logic [1:0]             interrupt_code_out,
    output logic [7:0]             interrupt_data_out,
    output logic                   interrupt_enable
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    logic [9:0]    mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic          wr_last_q, wr_last_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    data_q, data_d;
    logic          en_q, en_d;

    logic          wr_acc;
    logic          pop;
    logic          head_vis;
    logic          issue;
    logic [9:0]    head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        wr_acc    = wr_en && !full;
        head      = mem_q[rd_ptr_q];
        // an entry becomes eligible one cycle after it is stored
        head_vis  = (count_q > CW'(wr_last_q));
        issue     = head_vis && !hold && (head[9:8] != 2'b10 || vblank);
        pop       = 1'b0;
        state_d   = state_q;
        tmr_d     = tmr_q;
        code_d    = code_q;
        data_d    = data_q;
        en_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    pop     = 1'b1;
                    code_d  = head[9:8];
                    data_d  = head[7:0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = PULSE;
                en_d    = 1'b1;
                tmr_d   = TW'(PULSE_CYCLES - 1);
            end
            PULSE: begin
                if (tmr_q == '0) begin
                    state_d = GAP;
                    tmr_d   = TW'(GAP_CYCLES - 1);
                end else begin
                    en_d  = 1'b1;
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d  = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        wr_last_d = wr_acc;
        drop_d    = wr_en && full;
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
            wr_last_q <= 1'b0;
            code_q    <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            wr_last_q <= wr_last_d;
            code_q    <= code_d;
            data_q    <= data_d;
            en_q      <= en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= {wr_code, wr_data};
        end
    end

    assign count              = count_q;
    assign drop               = drop_q;
    assign interrupt_code_out = code_q;
    assign interrupt_data_out = data_q;
    assign interrupt_enable   = en_q;

endmodule

// File: tb/tb_gpu_cmd_fifo.sv
// Directed and randomized bench for gpu_cmd_fifo against a queue-based
// model of accepted commands and the documented pulse timing.
module tb_gpu_cmd_fifo;
    localparam int DEPTH = 16;
    localparam int NREC  = 512;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_code;
    logic [7:0] wr_data;
    logic       hold;
    logic       vblank;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       drop;
    logic [1:0] interrupt_code_out;
    logic [7:0] interrupt_data_out;
    logic       interrupt_enable;

    always #5 clk = ~clk;

    gpu_cmd_fifo #(.DEPTH(DEPTH), .PULSE_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_code(wr_code),
        .wr_data(wr_data), .hold(hold), .vblank(vblank), .full(full),
        .empty(empty), .count(count), .drop(drop),
        .interrupt_code_out(interrupt_code_out),
        .interrupt_data_out(interrupt_data_out),
        .interrupt_enable(interrupt_enable)
    );

    int checks = 0;
    int passed = 0;

    // monitor state: written only by the monitor process
    int         cyc = 0;
    int         n_rise = 0;
    int         stab_bad = 0;
    logic       en_prev = 1'b0;
    logic [9:0] cur = '0;
    logic [9:0] rise_cmd [NREC];
    int         rise_cyc [NREC];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #3;
        if (interrupt_enable === 1'b1 && !en_prev) begin
            cur = {interrupt_code_out, interrupt_data_out};
            if (n_rise < NREC) begin
                rise_cmd[n_rise] = cur;
                rise_cyc[n_rise] = cyc;
            end
            n_rise = n_rise + 1;
        end else if (interrupt_enable === 1'b1 &&
                     {interrupt_code_out, interrupt_data_out} !== cur) begin
            stab_bad = stab_bad + 1;
        end
        en_prev = (interrupt_enable === 1'b1);
    end

    // model: commands accepted but not yet seen on the interrupt port
    logic [9:0] exp_q [$];
    int         rd_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        logic [9:0] e;
        while (rd_idx < n_rise && rd_idx < NREC) begin
            if (exp_q.size() == 0) begin
                chk("extra_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("order", 32'(rise_cmd[rd_idx]), 32'(e));
            end
            rd_idx++;
        end
    endtask

    task automatic put(input logic [1:0] c, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_code = c;
        wr_data = d;
    endtask

    initial begin
        int w;
        int r0;
        int ok;
        logic [1:0] c;
        logic [7:0] d;
        logic acc;

        reset = 1'b1; wr_en = 1'b0; wr_code = '0; wr_data = '0;
        hold = 1'b0; vblank = 1'b1;
        repeat (3) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_en", 32'(interrupt_enable), 32'd0);
        chk("rst_code", 32'(interrupt_code_out), 32'd0);
        chk("rst_data", 32'(interrupt_data_out), 32'd0);
        reset = 1'b0;
        tick();

        // single command latency
        put(2'b00, 8'h41); exp_q.push_back({2'b00, 8'h41});
        tick(); wr_en = 1'b0; w = cyc;
        chk("t1_count_e0", 32'(count), 32'd1);
        tick();
        chk("t1_count_e1", 32'(count), 32'd1);
        chk("t1_en_e1", 32'(interrupt_enable), 32'd0);
        tick();
        chk("t1_count_e2", 32'(count), 32'd0);
        chk("t1_en_e2", 32'(interrupt_enable), 32'd0);
        tick();
        chk("t1_en_e3", 32'(interrupt_enable), 32'd1);
        chk("t1_code", 32'(interrupt_code_out), 32'd0);
        chk("t1_data", 32'(interrupt_data_out), 32'h41);
        tick();
        chk("t1_en_e4", 32'(interrupt_enable), 32'd1);
        tick();
        chk("t1_en_e5", 32'(interrupt_enable), 32'd0);
        chk("t1_data_gap", 32'(interrupt_data_out), 32'h41);
        repeat (3) tick();
        drain();
        chk("t1_rise_edge", 32'(rise_cyc[0]), 32'(w + 3));

        // three back-to-back commands
        r0 = n_rise;
        put(2'b00, 8'h10); exp_q.push_back({2'b00, 8'h10}); tick();
        put(2'b01, 8'h85); exp_q.push_back({2'b01, 8'h85}); tick();
        put(2'b11, 8'h00); exp_q.push_back({2'b11, 8'h00}); tick();
        wr_en = 1'b0;
        repeat (25) tick();
        drain();
        chk("t2_pulses", 32'(n_rise - r0), 32'd3);
        chk("t2_gap01", 32'(rise_cyc[r0 + 1] - rise_cyc[r0]), 32'd6);
        chk("t2_gap12", 32'(rise_cyc[r0 + 2] - rise_cyc[r0 + 1]), 32'd6);

        // fill under hold, overflow by one
        hold = 1'b1;
        r0 = n_rise;
        for (int i = 0; i < 17; i++) begin
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            acc = (exp_q.size() < DEPTH);
            if (acc) exp_q.push_back({c, d});
            put(c, d);
            tick();
            chk("t3_drop", 32'(drop), 32'(!acc));
            if (i == 15) begin
                chk("t3_full16", 32'(full), 32'd1);
                chk("t3_count16", 32'(count), 32'd16);
            end
        end
        wr_en = 1'b0;
        tick();
        chk("t3_drop_clear", 32'(drop), 32'd0);
        chk("t3_count_hold", 32'(count), 32'd16);
        chk("t3_no_pulse", 32'(n_rise - r0), 32'd0);
        hold = 1'b0;
        repeat (16 * 6 + 10) tick();
        drain();
        chk("t3_pulses", 32'(n_rise - r0), 32'd16);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_model_empty", 32'(exp_q.size()), 32'd0);

        // DISPLAY waits for vblank and blocks later commands
        vblank = 1'b0;
        r0 = n_rise;
        put(2'b10, 8'h00); exp_q.push_back({2'b10, 8'h00}); tick();
        put(2'b00, 8'h55); exp_q.push_back({2'b00, 8'h55}); tick();
        wr_en = 1'b0;
        repeat (100) tick();
        drain();
        chk("t4_blocked", 32'(n_rise - r0), 32'd0);
        chk("t4_count", 32'(count), 32'd2);
        vblank = 1'b1;
        repeat (20) tick();
        drain();
        chk("t4_pulses", 32'(n_rise - r0), 32'd2);
        chk("t4_spacing", 32'(rise_cyc[r0 + 1] - rise_cyc[r0]), 32'd6);

        // reset mid-pulse with four queued
        r0 = n_rise;
        for (int i = 0; i < 5; i++) begin
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            exp_q.push_back({c, d});
            put(c, d);
            tick();
        end
        chk("t5_en_mid", 32'(interrupt_enable), 32'd1);
        chk("t5_count_mid", 32'(count), 32'd4);
        reset = 1'b1;
        put(2'b01, 8'hAA);
        tick();
        wr_en = 1'b0;
        reset = 1'b0;
        chk("t5_en", 32'(interrupt_enable), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_code", 32'(interrupt_code_out), 32'd0);
        chk("t5_data", 32'(interrupt_data_out), 32'd0);
        drain();
        exp_q.delete();
        repeat (50) tick();
        chk("t5_no_more", 32'(n_rise - r0), 32'd1);
        chk("t5_count_after", 32'(count), 32'd0);

        // pointer wrap: 40 spaced writes
        r0 = n_rise;
        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            exp_q.push_back({c, d});
            put(c, d);
            tick();
            wr_en = 1'b0;
            chk("t6_drop", 32'(drop), 32'd0);
            repeat (5) tick();
        end
        repeat (20) tick();
        drain();
        chk("t6_pulses", 32'(n_rise - r0), 32'd40);
        chk("t6_model_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);

        // random traffic with hold and vblank toggling
        for (int i = 0; i < 400; i++) begin
            hold   = ($urandom_range(0, 7) == 0);
            vblank = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0 && exp_q.size() < DEPTH) begin
                c = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                exp_q.push_back({c, d});
                put(c, d);
            end else begin
                wr_en = 1'b0;
            end
            tick();
            drain();
            ok = (32'(count) == exp_q.size()) ||
                 (32'(count) + 1 == exp_q.size());
            chk("t7_count_window", 32'(ok), 32'd1);
            chk("t7_drop", 32'(drop), 32'd0);
        end
        wr_en = 1'b0; hold = 1'b0; vblank = 1'b1;
        repeat (16 * 6 + 20) tick();
        drain();
        chk("t7_model_empty", 32'(exp_q.size()), 32'd0);
        chk("t7_empty", 32'(empty), 32'd1);
        chk("stability", 32'(stab_bad), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
